// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction memory port, decode handshake and
// control-flow inputs.
interface instr_fetch_ctrl_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
);
   logic [ADDR_W-1:0] A_InstrAddress;
   logic              C_IMRead;
   logic [DATA_W-1:0] D_Instruction;
   logic              if_valid;
   logic [DATA_W-1:0] if_instr;
   logic [ADDR_W-1:0] if_pc;
   logic              id_ready;
   logic              C_Redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              C_Halt;
   logic              halted;

   modport master (
      output A_InstrAddress, C_IMRead, if_valid, if_instr, if_pc, halted,
      input  D_Instruction, id_ready, C_Redirect, redirect_pc, C_Halt
   );

   modport slave (
      input  A_InstrAddress, C_IMRead, if_valid, if_instr, if_pc, halted,
      output D_Instruction, id_ready, C_Redirect, redirect_pc, C_Halt
   );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues memory reads under a
// 2-credit scheme and queues {pc, instruction} pairs for decode.
module instr_fetch_ctrl #(
   parameter int unsigned       ADDR_W   = 16,
   parameter int unsigned       DATA_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic             clk,
   input logic             rst,
   instr_fetch_ctrl_if.master bus
);

   typedef enum logic [1:0] {StIdle, StFetch, StHalted} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] issued_pc_q, issued_pc_d;
   logic              inflight_q, inflight_d;
   logic [1:0]        count_q, count_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] buf_pc_q    [2];
   logic [DATA_W-1:0] buf_instr_q [2];

   logic head_valid, pop, push, issue, credit;

   assign head_valid = (count_q != 2'd0);
   assign pop        = head_valid && bus.id_ready;
   // Buffered plus in-flight entries never exceed the two buffer slots.
   assign credit     = ({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2;
   assign issue      = (state_q == StFetch) && !bus.C_Redirect && (credit || pop);
   assign push       = inflight_q && !bus.C_Redirect;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      issued_pc_d = issued_pc_q;
      inflight_d  = issue;
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;

      unique case (state_q)
         StIdle:   state_d = bus.C_Halt ? StHalted : StFetch;
         StFetch:  if (bus.C_Halt) state_d = StHalted;
         StHalted: if (bus.C_Redirect && !bus.C_Halt) state_d = StFetch;
         default:  state_d = StIdle;
      endcase

      if (bus.C_Redirect) begin
         pc_d     = bus.redirect_pc;
         count_d  = 2'd0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
      end else begin
         if (issue) begin
            pc_d        = pc_q + ADDR_W'(1);
            issued_pc_d = pc_q;
         end
         if (push) wr_ptr_d = ~wr_ptr_q;
         if (pop)  rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         pc_q        <= RESET_PC;
         issued_pc_q <= '0;
         inflight_q  <= 1'b0;
         count_q     <= 2'd0;
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         issued_pc_q <= issued_pc_d;
         inflight_q  <= inflight_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_pc_q[0]    <= '0;
         buf_pc_q[1]    <= '0;
         buf_instr_q[0] <= '0;
         buf_instr_q[1] <= '0;
      end else if (push) begin
         buf_pc_q[wr_ptr_q]    <= issued_pc_q;
         buf_instr_q[wr_ptr_q] <= bus.D_Instruction;
      end
   end

   assign bus.A_InstrAddress = pc_q;
   assign bus.C_IMRead       = issue;
   assign bus.if_valid       = head_valid;
   // Stale slots stay hidden so an empty buffer always presents zeros.
   assign bus.if_pc          = head_valid ? buf_pc_q[rd_ptr_q]    : '0;
   assign bus.if_instr       = head_valid ? buf_instr_q[rd_ptr_q] : '0;
   assign bus.halted         = (state_q == StHalted);

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Fetch sequencer for the 16-bit processor's instruction memory. It owns the program counter, issues `C_IMRead`/`A_InstrAddress` to `instructionMemory`, captures `D_Instruction` into a 2-entry instruction buffer, and hands `{pc, instruction}` pairs to decode over a valid/ready handshake. It also handles control-flow redirects and halt.

## Interface
- `ADDR_W`, 16: instruction address width (word addressed).
- `DATA_W`, 16: instruction width.
- `RESET_PC`, 16'h0000: PC loaded on reset.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `A_InstrAddress`  out  ADDR_W  read address to instruction memory (= PC register).
- `C_IMRead`  out  1  read strobe to instruction memory.
- `D_Instruction`  in  DATA_W  memory read data, valid exactly 1 cycle after the strobe.
- `if_valid`  out  1  buffer head valid toward decode.
- `if_instr`  out  DATA_W  head instruction.
- `if_pc`  out  ADDR_W  address of the head instruction.
- `id_ready`  in  1  decode accepts the head this cycle.
- `C_Redirect`  in  1  branch/jump taken; flush and refetch.
- `redirect_pc`  in  ADDR_W  target address, sampled when `C_Redirect`=1.
- `C_Halt`  in  1  stop issuing fetches.
- `halted`  out  1  high in HALTED state.

## Operation
- FSM states: IDLE (after reset), FETCH, HALTED.
  - IDLE -> FETCH on the first clock edge after `rst` releases.
  - FETCH -> HALTED when `C_Halt`=1.
  - HALTED -> FETCH only on `C_Redirect`=1 with `C_Halt`=0.
- Issue: `C_IMRead` = (state==FETCH) && !`C_Redirect` && (count+inflight<2 || pop), where pop = `if_valid`&&`id_ready`. Combinational; `A_InstrAddress` = PC.
- On issue: PC <= PC+1, wrapping mod 2^ADDR_W (16'hFFFF -> 16'h0000). issued_pc <= PC. inflight <= 1. With no issue, inflight <= 0.
- Response: the cycle after an unsquashed issue, push {issued_pc, `D_Instruction`} into the buffer.
- Buffer: 2-entry FIFO with count 0..2. Push and pop in the same cycle are legal. The credit rule makes overflow impossible. `if_valid` = (count!=0).
- Redirect (priority over everything in that cycle):
  - PC <= `redirect_pc`; buffer flushed (count <= 0); in-flight response squashed (not pushed); no issue that cycle.
  - A decode handshake in the redirect cycle still completes; the flush discards all remaining entries.
- Halt: no new issues. The in-flight response is still pushed and buffered entries still drain to decode. `halted`=1.
- Redirect and halt in the same cycle: PC load and flush take effect; state becomes HALTED.
- Reset (async, any time, including mid-stream): PC=RESET_PC, count=0, inflight=0, state=IDLE.
- Reset values of outputs: `A_InstrAddress`=RESET_PC, `C_IMRead`=0, `if_valid`=0, `if_instr`=0, `if_pc`=0, `halted`=0.

## Timing
- Edge E0 = first rising edge with `rst` high. `C_IMRead`=1 with `A_InstrAddress`=RESET_PC in the cycle after E0.
- Fetch-to-decode latency is 2 cycles: issue in cycle N, `D_Instruction` in cycle N+1, `if_valid` with that entry in cycle N+2.
- Steady state with `id_ready`=1: one instruction per cycle, no bubbles.
- Redirect in cycle R:
  - `if_valid`=0 in R+1.
  - Target issued in R+1.
  - First target instruction at decode in R+3.
- `id_ready`=0: the buffer fills to 2 and issue stops. On release, issue resumes in the same cycle as the pop.

## Test plan
- Reset, then stream with `id_ready`=1 and mem[i]=16'hA000+i:
  - `C_IMRead` rises 1 cycle after E0.
  - `if_valid` first at E0+3 with pc=0, instr=A000.
  - Thereafter pc 1, 2, 3… on consecutive cycles.
- Backpressure: hold `id_ready`=0 for 5 cycles mid-stream.
  - count stays ≤2, `C_IMRead` drops, no instruction lost or duplicated.
  - Sequence resumes contiguously after release.
- Redirect to 16'h0040 while buffer full and a read in flight:
  - Squashed entries never appear at decode.
  - Next valid pc is 16'h0040, 3 cycles after redirect.
- `C_Halt` pulse at pc=5:
  - Buffered and in-flight entries drain.
  - `halted`=1, no further `C_IMRead`.
  - Redirect to 16'h0010 resumes fetching from 16'h0010.
- Wrap: redirect to 16'hFFFE.
  - Decode sees pc FFFE, FFFF, 0000, 0001 in order.
- Async reset asserted mid-stream, between clock edges:
  - Outputs return to their reset values immediately.
  - After release, fetching restarts at RESET_PC.
